vga_frame_ctrl: RTL and testbench

Frame scheduler for the colour-space conversion datapath. It generates VGA raster timing for an H_DISP×V_DISP image, issues sequential pixel-read requests to the source image memory, and delays hsync/vsync/de by the conversion pipeline latency so that they align with the converted pixel data. It sits in `top` between the image ROM and the RGB→HSI pipeline. It drives `VGA_hsync`, `VGA_vsync` and `VGA_de` toward the display and the simulation bench.

---
 rtl/vga_frame_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_vga_frame_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_ctrl.sv
// vga_frame_ctrl: VGA raster timing, sequential ROM read strobes and PIPE_LAT-aligned hsync/vsync/de.
// Define VGA_SINGLE_FRAME_EN for one frame per start; by default frames repeat back to back.
module vga_frame_ctrl #(
  parameter int H_DISP   = 400,
  parameter int V_DISP   = 306,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_FRONT  = 10,
  parameter int PIPE_LAT = 5,
  parameter int ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              VGA_hsync,
  output logic              VGA_vsync,
  output logic              VGA_de,
  output logic              busy,
  output logic              frame_done
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_LO   = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0] H_ACT_HI   = HW'(H_SYNC + H_BACK + H_DISP - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_LO   = VW'(V_SYNC + V_BACK);
  localparam logic [VW-1:0] V_ACT_HI   = VW'(V_SYNC + V_BACK + V_DISP - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_DISP * V_DISP - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [HW-1:0]       h_cnt_q, h_cnt_d;
  logic [VW-1:0]       v_cnt_q, v_cnt_d;
  logic [DW-1:0]       drain_cnt_q, drain_cnt_d;
  logic                rom_rd_q, rom_rd_d;
  logic                hs_raw_q, hs_raw_d;
  logic                vs_raw_q, vs_raw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [PIPE_LAT-1:0] de_pipe_q, de_pipe_d;
  logic [PIPE_LAT-1:0] hs_pipe_q, hs_pipe_d;
  logic [PIPE_LAT-1:0] vs_pipe_q, vs_pipe_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
`ifndef VGA_SINGLE_FRAME_EN
  logic [PIPE_LAT-1:0] last_pipe_q, last_pipe_d;
`endif

  // Next-state and raster counter logic
  always_comb begin
    state_d     = state_q;
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    drain_cnt_d = '0;
    case (state_q)
      IDLE: begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (start) state_d = RUN;
        else       state_d = IDLE;
      end
      RUN: begin
        if (h_cnt_q == H_LAST) begin
          h_cnt_d = '0;
          if (v_cnt_q == V_LAST) begin
            v_cnt_d = '0;
`ifdef VGA_SINGLE_FRAME_EN
            state_d = DRAIN;
`else
            state_d = RUN;
`endif
          end else begin
            v_cnt_d = v_cnt_q + 1'b1;
          end
        end else begin
          h_cnt_d = h_cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) state_d = DONE;
        else                           drain_cnt_d = drain_cnt_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Raw raster signals, address and delay line; raw flags come from next counts so the flops line up with them
  always_comb begin
    hs_raw_d = 1'b1;
    vs_raw_d = 1'b1;
    rom_rd_d = 1'b0;
    if (state_d == RUN) begin
      hs_raw_d = (h_cnt_d >= H_SYNC_END);
      vs_raw_d = (v_cnt_d >= V_SYNC_END);
      rom_rd_d = (h_cnt_d >= H_ACT_LO) && (h_cnt_d <= H_ACT_HI) &&
                 (v_cnt_d >= V_ACT_LO) && (v_cnt_d <= V_ACT_HI);
    end else begin
      rom_rd_d = 1'b0;
    end

    if (state_q != RUN)         addr_d = '0;
    else if (!rom_rd_q)         addr_d = addr_q;
    else if (addr_q == ADDR_LAST) addr_d = '0;
    else                        addr_d = addr_q + 1'b1;

    de_pipe_d = PIPE_LAT'({de_pipe_q, rom_rd_q});
    hs_pipe_d = PIPE_LAT'({hs_pipe_q, hs_raw_q});
    vs_pipe_d = PIPE_LAT'({vs_pipe_q, vs_raw_q});
    busy_d    = (state_d != IDLE);
`ifdef VGA_SINGLE_FRAME_EN
    frame_done_d = (state_d == DONE);
`else
    last_pipe_d  = PIPE_LAT'({last_pipe_q, (rom_rd_q && (addr_q == ADDR_LAST))});
    frame_done_d = last_pipe_q[PIPE_LAT-1];
`endif
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      drain_cnt_q  <= '0;
      rom_rd_q     <= 1'b0;
      hs_raw_q     <= 1'b1;
      vs_raw_q     <= 1'b1;
      addr_q       <= '0;
      de_pipe_q    <= '0;
      hs_pipe_q    <= '1;
      vs_pipe_q    <= '1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifndef VGA_SINGLE_FRAME_EN
      last_pipe_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      rom_rd_q     <= rom_rd_d;
      hs_raw_q     <= hs_raw_d;
      vs_raw_q     <= vs_raw_d;
      addr_q       <= addr_d;
      de_pipe_q    <= de_pipe_d;
      hs_pipe_q    <= hs_pipe_d;
      vs_pipe_q    <= vs_pipe_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
`ifndef VGA_SINGLE_FRAME_EN
      last_pipe_q  <= last_pipe_d;
`endif
    end
  end

  assign rom_rd     = rom_rd_q;
  assign rom_addr   = addr_q;
  assign VGA_de     = de_pipe_q[PIPE_LAT-1];
  assign VGA_hsync  = hs_pipe_q[PIPE_LAT-1];
  assign VGA_vsync  = vs_pipe_q[PIPE_LAT-1];
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_vga_frame_ctrl.sv
// Directed bench for vga_frame_ctrl using small raster parameters (8x6 total, 4x3 active, 3-clock latency).
module tb_vga_frame_ctrl;

  localparam int N  = 100;
  localparam int PL = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        rom_rd;
  logic [16:0] rom_addr;
  logic        VGA_hsync, VGA_vsync, VGA_de, busy, frame_done;

  int checks = 0;
  int errors = 0;

  logic        rd_a   [N];
  logic [16:0] addr_a [N];
  logic        de_a   [N];
  logic        hs_a   [N];
  logic        vs_a   [N];
  logic        fd_a   [N];
  logic        busy_a [N];

  vga_frame_ctrl #(
    .H_DISP(4), .V_DISP(3), .H_SYNC(2), .H_BACK(1), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .V_FRONT(1), .PIPE_LAT(PL), .ADDR_W(17)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_rd(rom_rd), .rom_addr(rom_addr),
    .VGA_hsync(VGA_hsync), .VGA_vsync(VGA_vsync), .VGA_de(VGA_de),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Samples N cycles starting at the current (first RUN) cycle
  task automatic capture();
    for (int k = 0; k < N; k++) begin
      rd_a[k]   = rom_rd;
      addr_a[k] = rom_addr;
      de_a[k]   = VGA_de;
      hs_a[k]   = VGA_hsync;
      vs_a[k]   = VGA_vsync;
      fd_a[k]   = frame_done;
      busy_a[k] = busy;
      tick();
    end
  endtask

  task automatic analyze(input string tag);
    int first_rd, first_de, rd_cnt, bad_addr, de_cnt, de_runs, hs_low, vs_low;
    int fd_cnt, fd_first, fd_second;
    first_rd = -1; first_de = -1; rd_cnt = 0; bad_addr = 0;
    de_cnt = 0; de_runs = 0; hs_low = 0; vs_low = 0;
    fd_cnt = 0; fd_first = -1; fd_second = -1;
    for (int k = 0; k < 48; k++) begin
      if (rd_a[k]) begin
        if (first_rd < 0) first_rd = k;
        if (addr_a[k] !== 17'(rd_cnt)) bad_addr++;
        rd_cnt++;
      end
    end
    for (int k = PL; k < PL + 48; k++) begin
      if (de_a[k]) begin
        if (first_de < 0) first_de = k;
        de_cnt++;
        if (!de_a[k-1]) de_runs++;
      end
      if (hs_a[k] === 1'b0) hs_low++;
      if (vs_a[k] === 1'b0) vs_low++;
    end
    for (int k = 0; k < N; k++) begin
      if (fd_a[k]) begin
        fd_cnt++;
        if (fd_first < 0) fd_first = k;
        else if (fd_second < 0) fd_second = k;
      end
    end
    check({tag, " busy_run0"}, 32'(busy_a[0]), 32'd1);
    check({tag, " first_rd"}, 32'(first_rd), 32'd19);
    check({tag, " first_addr"}, 32'(addr_a[19]), 32'd0);
    check({tag, " first_de"}, 32'(first_de), 32'd22);
    check({tag, " rd_count"}, 32'(rd_cnt), 32'd12);
    check({tag, " addr_order"}, 32'(bad_addr), 32'd0);
    check({tag, " de_count"}, 32'(de_cnt), 32'd12);
    check({tag, " de_runs"}, 32'(de_runs), 32'd3);
    check({tag, " hsync_first"}, 32'({hs_a[PL], hs_a[PL+1], hs_a[PL+2]}), 32'b001);
    check({tag, " hsync_low"}, 32'(hs_low), 32'd12);
    check({tag, " vsync_low"}, 32'(vs_low), 32'd8);
`ifdef VGA_SINGLE_FRAME_EN
    check({tag, " fd_index"}, 32'(fd_first), 32'd51);
    check({tag, " fd_count"}, 32'(fd_cnt), 32'd1);
    check({tag, " busy_done"}, 32'(busy_a[51]), 32'd1);
    check({tag, " busy_after"}, 32'(busy_a[52]), 32'd0);
    check({tag, " no_rd_idle"}, 32'(rd_a[60]), 32'd0);
`else
    check({tag, " fd_index"}, 32'(fd_first), 32'd42);
    check({tag, " fd_second"}, 32'(fd_second), 32'd90);
    check({tag, " fd_count"}, 32'(fd_cnt), 32'd2);
    check({tag, " frame2_rd"}, 32'({rd_a[66], rd_a[67]}), 32'b01);
    check({tag, " frame2_addr"}, 32'(addr_a[67]), 32'd0);
    check({tag, " busy_stays"}, 32'(busy_a[N-1]), 32'd1);
`endif
  endtask

  initial begin
    int activity;
    rst_n = 1'b0;
    start = 1'b0;
    tick();
    tick();
    check("rst rom_rd", 32'(rom_rd), 32'd0);
    check("rst rom_addr", 32'(rom_addr), 32'd0);
    check("rst de", 32'(VGA_de), 32'd0);
    check("rst hsync", 32'(VGA_hsync), 32'd1);
    check("rst vsync", 32'(VGA_vsync), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst frame_done", 32'(frame_done), 32'd0);

    rst_n = 1'b1;
    activity = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (rom_rd || busy || VGA_de || frame_done || !VGA_hsync || !VGA_vsync) activity++;
    end
    check("idle activity", 32'(activity), 32'd0);

    start = 1'b1;
    tick();
    start = 1'b0;
    capture();
    analyze("frame1");

`ifdef VGA_SINGLE_FRAME_EN
    start = 1'b1;
    tick();
    start = 1'b0;
    capture();
    analyze("frame2");
`endif

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 28; k++) tick();
    check("mid rom_rd", 32'(rom_rd), 32'd1);
    check("mid rom_addr", 32'(rom_addr), 32'd5);
    rst_n = 1'b0;
    tick();
    check("abort de", 32'(VGA_de), 32'd0);
    check("abort rom_addr", 32'(rom_addr), 32'd0);
    check("abort rom_rd", 32'(rom_rd), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort frame_done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    activity = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (rom_rd || busy || frame_done || VGA_de) activity++;
    end
    check("abort stays idle", 32'(activity), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
